// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: the two requester ports (CPU on port 0, debug/DMA loader
// on port 1) plus the arbiter's side of the 32x32 data RAM.
//   Req/We/Addr/Din   request from each port
//   Gnt/Ack/Rdata/Err grant, completion strobe, read data and reject flag
//   MAddr/MDin/MWe    RAM address, write data and write enable
//   MDout             combinational RAM read data for MAddr
// slave  = arbiter side; master = requesters and RAM side.
interface dmem_arbiter_if;
  logic        Req0, Req1;
  logic        We0, We1;
  logic [31:0] Addr0, Addr1;
  logic [31:0] Din0, Din1;
  logic        Gnt0, Gnt1;
  logic        Ack0, Ack1;
  logic [31:0] Rdata;
  logic        Err;
  logic [31:0] MAddr;
  logic [31:0] MDin;
  logic        MWe;
  logic [31:0] MDout;

  modport slave (
    input  Req0, Req1, We0, We1, Addr0, Addr1, Din0, Din1, MDout,
    output Gnt0, Gnt1, Ack0, Ack1, Rdata, Err, MAddr, MDin, MWe
  );

  modport master (
    output Req0, Req1, We0, We1, Addr0, Addr1, Din0, Din1, MDout,
    input  Gnt0, Gnt1, Ack0, Ack1, Rdata, Err, MAddr, MDin, MWe
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a 32x32 data RAM.
// Each access takes one ACC cycle, where the RAM is driven, then one ACK
// cycle, where the served port gets a single Ack strobe. From ACK the arbiter
// goes straight to ACC for the other port if it is waiting, so two busy ports
// alternate with no idle gap.
// Ports:
//   Clk   clock, rising edge
//   Rst   synchronous reset, active high
//   bus   dmem_arbiter_if.slave (request ports and RAM side)
// FIXED_PRI: 0 = round robin on IDLE conflicts, 1 = port 0 wins them.
module dmem_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input logic           Clk,
  input logic           Rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t            state, state_nxt;
  logic              sel, sel_nxt;    // port being served
  logic              last;            // port served most recently
  logic [31:0]       rdata_q;
  logic              err_q;

  // Both ports as packed arrays, indexed by sel
  logic [1:0]        req, we;
  logic [1:0][31:0]  addr, din;
  logic [1:0]        gnt, ack;
  logic              err_c;
  logic [31:0]       maddr, mdin;
  logic              mwe;

  assign req  = {bus.Req1, bus.Req0};
  assign we   = {bus.We1, bus.We0};
  assign addr = {bus.Addr1, bus.Addr0};
  assign din  = {bus.Din1, bus.Din0};

  // Only word-aligned addresses inside the 128-byte RAM are legal
  assign err_c = (|addr[sel][31:7]) | (|addr[sel][1:0]);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    gnt       = '0;
    ack       = '0;
    maddr     = '0;
    mdin      = '0;
    mwe       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ACC;
          if (&req) sel_nxt = FIXED_PRI ? 1'b0 : ~last;
          else      sel_nxt = req[1];
        end
      end
      ACC: begin
        gnt[sel]  = 1'b1;
        maddr     = addr[sel];
        mdin      = din[sel];
        // Rst in the same cycle kills the write before it reaches the RAM
        mwe       = we[sel] & ~err_c & ~Rst;
        state_nxt = ACK;
      end
      ACK: begin
        ack[sel] = 1'b1;
        // The served port's own Req is ignored here; only the other port
        // can chain straight into a new access.
        if (req[~sel]) begin
          sel_nxt   = ~sel;
          state_nxt = ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;   // makes the first round-robin conflict go to port 0
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (state == ACC) begin
        rdata_q <= (~we[sel] & ~err_c) ? bus.MDout : 32'd0;
        err_q   <= err_c;
      end
      if (state == ACK) last <= sel;
    end
  end

  assign bus.Gnt0  = gnt[0];
  assign bus.Gnt1  = gnt[1];
  assign bus.Ack0  = ack[0];
  assign bus.Ack1  = ack[1];
  assign bus.Rdata = rdata_q;
  assign bus.Err   = (state == ACK) & err_q;
  assign bus.MAddr = maddr;
  assign bus.MDin  = mdin;
  assign bus.MWe   = mwe;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (a) and a fixed-priority
// instance (b) get the same port stimulus, each with its own 32x32 RAM.
// One vector = one clock cycle: inputs applied after the falling edge,
// outputs compared 1 ns later, state advances on the next rising edge.
module tb_dmem_arbiter;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        mem_init;
  logic        r0, r1, w0, w1;
  logic [31:0] a0, a1, d0, d1;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  dmem_arbiter_if ifa ();
  dmem_arbiter_if ifb ();

  assign ifa.Req0 = r0;  assign ifa.Req1 = r1;
  assign ifa.We0  = w0;  assign ifa.We1  = w1;
  assign ifa.Addr0 = a0; assign ifa.Addr1 = a1;
  assign ifa.Din0  = d0; assign ifa.Din1  = d1;
  assign ifb.Req0 = r0;  assign ifb.Req1 = r1;
  assign ifb.We0  = w0;  assign ifb.We1  = w1;
  assign ifb.Addr0 = a0; assign ifb.Addr1 = a1;
  assign ifb.Din0  = d0; assign ifb.Din1  = d1;

  dmem_arbiter #(.FIXED_PRI(1'b0)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
  dmem_arbiter #(.FIXED_PRI(1'b1)) dut_b (.Clk(Clk), .Rst(Rst), .bus(ifb));

  // RAMs, preloaded with A000_0000 + word index
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  assign ifa.MDout = mem_a[ifa.MAddr[6:2]];
  assign ifb.MDout = mem_b[ifb.MAddr[6:2]];

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 32'hA000_0000 + i;
        mem_b[i] <= 32'hA000_0000 + i;
      end
    end else begin
      if (ifa.MWe) mem_a[ifa.MAddr[6:2]] <= ifa.MDin;
      if (ifb.MWe) mem_b[ifb.MAddr[6:2]] <= ifb.MDin;
    end
  end

  typedef struct {
    logic        rst, r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  g, ak;     // dut_a {Gnt1,Gnt0}, {Ack1,Ack0}
    logic        er;
    logic [31:0] rd;
    logic        mwe;
    logic [31:0] ma;
    logic [1:0]  gb, ab;    // dut_b {Gnt1,Gnt0}, {Ack1,Ack0}
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic rst, r0_, r1_, w0_, w1_,
                             input logic [31:0] a0_, a1_, d0_, d1_,
                             input logic [1:0] g, ak, input logic er,
                             input logic [31:0] rd, input logic mwe,
                             input logic [31:0] ma, input logic [1:0] gb, ab);
    vec_t t;
    t.rst = rst; t.r0 = r0_; t.r1 = r1_; t.w0 = w0_; t.w1 = w1_;
    t.a0 = a0_; t.a1 = a1_; t.d0 = d0_; t.d1 = d1_;
    t.g = g; t.ak = ak; t.er = er; t.rd = rd; t.mwe = mwe; t.ma = ma;
    t.gb = gb; t.ab = ab;
    return t;
  endfunction

  function automatic logic [73:0] pack_exp(input vec_t t);
    return {t.g, t.ak, t.er, t.rd, t.mwe, t.ma, t.gb, t.ab};
  endfunction

  function automatic logic [73:0] pack_act();
    return {ifa.Gnt1, ifa.Gnt0, ifa.Ack1, ifa.Ack0, ifa.Err, ifa.Rdata,
            ifa.MWe, ifa.MAddr, ifb.Gnt1, ifb.Gnt0, ifb.Ack1, ifb.Ack0};
  endfunction

  task automatic check_mem(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] M1 = 32'hA000_0001;
  localparam logic [31:0] M2 = 32'hA000_0002;

  initial begin
    logic [1:0] eak, eab;
    // fields: rst r0 r1 w0 w1 | a0 a1 d0 d1 | g ak er rd mwe ma | gb ab
    // port0 write 0x10 then read it back
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,                     0,0,0,0, 0,0,       0,0));
    tv.push_back(v(0,1,0,1,0, 'h10,0,DB,0,                 0,0,0,0, 0,0,       0,0));
    tv.push_back(v(0,1,0,1,0, 'h10,0,DB,0,                 1,0,0,0, 1,'h10,    1,0));
    tv.push_back(v(0,0,0,1,0, 'h10,0,DB,0,                 0,1,0,0, 0,0,       0,1));
    tv.push_back(v(0,1,0,0,0, 'h10,0,0,0,                  0,0,0,0, 0,0,       0,0));
    tv.push_back(v(0,1,0,0,0, 'h10,0,0,0,                  1,0,0,0, 0,'h10,    1,0));
    tv.push_back(v(0,0,0,0,0, 'h10,0,0,0,                  0,1,0,DB,0,0,       0,1));
    // both reading, Last=0: a serves 1 first, b serves 0 first, then alternate
    tv.push_back(v(0,1,1,0,0, 'h10,'h04,0,0,               0,0,0,DB,0,0,       0,0));
    tv.push_back(v(0,1,1,0,0, 'h10,'h04,0,0,               2,0,0,DB,0,'h04,    1,0));
    tv.push_back(v(0,1,1,0,0, 'h10,'h04,0,0,               0,2,0,M1,0,0,       0,1));
    tv.push_back(v(0,1,1,0,0, 'h10,'h04,0,0,               1,0,0,M1,0,'h10,    2,0));
    tv.push_back(v(0,1,1,0,0, 'h10,'h04,0,0,               0,1,0,DB,0,0,       0,2));
    tv.push_back(v(0,1,1,0,0, 'h10,'h04,0,0,               2,0,0,DB,0,'h04,    1,0));
    tv.push_back(v(0,0,0,0,0, 'h10,'h04,0,0,               0,2,0,M1,0,0,       0,1));
    // port1 rejected writes: out of range 0x80, misaligned 0x13
    tv.push_back(v(0,0,1,0,1, 0,'h80,0,'h12345678,         0,0,0,M1,0,0,       0,0));
    tv.push_back(v(0,0,1,0,1, 0,'h80,0,'h12345678,         2,0,0,M1,0,'h80,    2,0));
    tv.push_back(v(0,0,0,0,1, 0,'h80,0,'h12345678,         0,2,1,0, 0,0,       0,2));
    tv.push_back(v(0,0,1,0,1, 0,'h13,0,'h12345678,         0,0,0,0, 0,0,       0,0));
    tv.push_back(v(0,0,1,0,1, 0,'h13,0,'h12345678,         2,0,0,0, 0,'h13,    2,0));
    tv.push_back(v(0,0,0,0,1, 0,'h13,0,'h12345678,         0,2,1,0, 0,0,       0,2));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,                     0,0,0,0, 0,0,       0,0));
    // reset during port0 ACC write to 0x08
    tv.push_back(v(0,1,0,1,0, 'h08,0,'hCAFEF00D,0,         0,0,0,0, 0,0,       0,0));
    tv.push_back(v(1,1,0,1,0, 'h08,0,'hCAFEF00D,0,         1,0,0,0, 0,'h08,    1,0));
    tv.push_back(v(0,0,0,0,0, 'h08,0,0,0,                  0,0,0,0, 0,0,       0,0));
    // port0 read with Req dropped during ACC
    tv.push_back(v(0,1,0,0,0, 'h08,0,0,0,                  0,0,0,0, 0,0,       0,0));
    tv.push_back(v(0,0,0,0,0, 'h08,0,0,0,                  1,0,0,0, 0,'h08,    1,0));
    tv.push_back(v(0,0,0,0,0, 'h08,0,0,0,                  0,1,0,M2,0,0,       0,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,                     0,0,0,M2,0,0,       0,0));
    // IDLE conflict with Last=0: round robin picks 1, fixed priority picks 0
    tv.push_back(v(0,1,1,0,0, 'h08,'h04,0,0,               0,0,0,M2,0,0,       0,0));
    tv.push_back(v(0,1,1,0,0, 'h08,'h04,0,0,               2,0,0,M2,0,'h04,    1,0));
    tv.push_back(v(0,0,0,0,0, 'h08,'h04,0,0,               0,2,0,M1,0,0,       0,1));
    tv.push_back(v(0,0,0,0,0, 0,0,0,0,                     0,0,0,M1,0,0,       0,0));
    // highest legal word, 0x7C
    tv.push_back(v(0,1,0,1,0, 'h7C,0,'h11112222,0,         0,0,0,M1,0,0,       0,0));
    tv.push_back(v(0,1,0,1,0, 'h7C,0,'h11112222,0,         1,0,0,M1,1,'h7C,    1,0));
    tv.push_back(v(0,0,0,1,0, 'h7C,0,'h11112222,0,         0,1,0,0, 0,0,       0,1));

    mem_init = 1'b1; Rst = 1'b1;
    r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      Rst = tv[i].rst; r0 = tv[i].r0; r1 = tv[i].r1; w0 = tv[i].w0; w1 = tv[i].w1;
      a0 = tv[i].a0; a1 = tv[i].a1; d0 = tv[i].d0; d1 = tv[i].d1;
      #1;
      checks++;
      if (pack_act() !== pack_exp(tv[i])) begin
        errors++;
        $display("FAIL vec%0d: got g=%b ak=%b er=%b rd=%h mwe=%b ma=%h gb=%b ab=%b want g=%b ak=%b er=%b rd=%h mwe=%b ma=%h gb=%b ab=%b",
                 i, {ifa.Gnt1, ifa.Gnt0}, {ifa.Ack1, ifa.Ack0}, ifa.Err, ifa.Rdata,
                 ifa.MWe, ifa.MAddr, {ifb.Gnt1, ifb.Gnt0}, {ifb.Ack1, ifb.Ack0},
                 tv[i].g, tv[i].ak, tv[i].er, tv[i].rd, tv[i].mwe, tv[i].ma,
                 tv[i].gb, tv[i].ab);
      end
      @(negedge Clk);
    end

    check_mem("ram_a_w4", mem_a[4], DB);
    check_mem("ram_a_w0", mem_a[0], 32'hA000_0000);
    check_mem("ram_a_w2", mem_a[2], M2);
    check_mem("ram_b_w2", mem_b[2], M2);
    check_mem("ram_a_w31", mem_a[31], 32'h1111_2222);

    // Both ports held high: Ack every other cycle, alternating ports, no gap.
    // Both instances have Last=0 here, so a starts on port 1, b on port 0.
    r0 = 1; r1 = 1; w0 = 0; w1 = 0; a0 = 32'h10; a1 = 32'h04;
    for (int k = 0; k < 12; k++) begin
      #1;
      eak = 2'b00; eab = 2'b00;
      if (k >= 2 && k % 2 == 0) begin
        eak = ((k / 2) % 2 == 1) ? 2'b10 : 2'b01;
        eab = ((k / 2) % 2 == 1) ? 2'b01 : 2'b10;
      end
      checks++;
      if ({ifa.Ack1, ifa.Ack0, ifb.Ack1, ifb.Ack0} !== {eak, eab}) begin
        errors++;
        $display("FAIL stream%0d: got ack_a=%b ack_b=%b want ack_a=%b ack_b=%b",
                 k, {ifa.Ack1, ifa.Ack0}, {ifb.Ack1, ifb.Ack0}, eak, eab);
      end
      @(negedge Clk);
    end
    r0 = 0; r1 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
